// File: rtl/rank_filter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rank_filter_pkg                                              |
// | Description : Shared mode encodings and elaboration helpers for the rank   |
// |               window filter and its comparator node.                       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package rank_filter_pkg;

  typedef enum logic [1:0] {
    MODE_MAX = 2'b00,
    MODE_MIN = 2'b01,
    MODE_CTR = 2'b10
  } mode_e;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < value) begin
      v = v * 2;
      r++;
    end
    return r;
  endfunction

  // Number of (value, idx) nodes present at tree level lvl (level 0 = taps).
  function automatic int nodes_at(input int taps, input int lvl);
    int n;
    n = taps;
    for (int k = 0; k < lvl; k++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

  // Offset of level lvl (lvl >= 1) inside the flattened registered-node array.
  function automatic int level_off(input int taps, input int lvl);
    int off;
    off = 0;
    for (int k = 1; k < lvl; k++) begin
      off += nodes_at(taps, k);
    end
    return off;
  endfunction

  // Folds the reserved encoding 11 onto max so the datapath sees only 3 modes.
  function automatic logic [1:0] mode_norm(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      MODE_MIN: r = MODE_MIN;
      MODE_CTR: r = MODE_CTR;
      default:  r = MODE_MAX;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rank_sel2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rank_sel2                                                    |
// | Description : Combinational two-input rank selector. Picks the larger     |
// |               (max) or smaller (min) value; equal values go to the lower   |
// |               tap index. In centre mode the lower index simply wins.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rank_sel2
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IDX_W  = 3
) (
  input  logic [1:0]        mode_i,
  input  logic [DATA_W-1:0] a_val_i,
  input  logic [IDX_W-1:0]  a_idx_i,
  input  logic [DATA_W-1:0] b_val_i,
  input  logic [IDX_W-1:0]  b_idx_i,
  output logic [DATA_W-1:0] val_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic b_wins;

  // Decide whether input b beats input a under the current mode.
  always_comb begin
    b_wins = 1'b0;
    case (mode_i)
      MODE_MIN: b_wins = (b_val_i < a_val_i) ||
                         ((b_val_i == a_val_i) && (b_idx_i < a_idx_i));
      MODE_CTR: b_wins = (b_idx_i < a_idx_i);
      default:  b_wins = (b_val_i > a_val_i) ||
                         ((b_val_i == a_val_i) && (b_idx_i < a_idx_i));
    endcase
    val_o = b_wins ? b_val_i : a_val_i;
    idx_o = b_wins ? b_idx_i : a_idx_i;
  end

endmodule
`default_nettype wire

// File: rtl/rank_window_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rank_window_filter                                           |
// | Description : Streaming 1-D rank filter. Slides a TAPS-wide window along   |
// |               each line and emits the max, min or centre sample plus its   |
// |               tap index through a registered comparator tree with a        |
// |               single global stall enable.                                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rank_window_filter
  import rank_filter_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int TAPS   = 5,
  parameter int IDX_W  = clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_sol
);

  // Tree depth, total registered nodes over levels 1..S, fill counter width.
  localparam int S     = clog2(TAPS);
  localparam int NODES = level_off(TAPS, S + 1);
  localparam int CNT_W = IDX_W + 1;
  localparam int CTR   = TAPS / 2;
  localparam logic [CNT_W-1:0] FILL_FULL = CNT_W'(TAPS);
  localparam logic [IDX_W-1:0] CTR_IDX   = IDX_W'(CTR);

  logic en;
  logic accept;

  // Window and line-tracking state.
  logic [DATA_W-1:0] win_q [TAPS];
  logic [DATA_W-1:0] win_d [TAPS];
  logic [CNT_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]  fill_base, fill_inc;
  logic              fill_done;
  logic              sol_flag;
  logic              sol_pend_q, sol_pend_d;
  logic [1:0]        mode_q, mode_d;
  logic              win_vld_d, win_sol_d;

  // Per-stage side-band: index 0 is the window stage, index l is tree level l.
  logic [S:0]        vld_q;
  logic [S:0]        sol_q;
  logic [1:0]        smode_q [S];

  // Tree leaves and registered tree nodes (all levels flattened).
  logic [DATA_W-1:0] leaf_val [TAPS];
  logic [IDX_W-1:0]  leaf_idx [TAPS];
  logic [DATA_W-1:0] node_val_q [NODES];
  logic [DATA_W-1:0] node_val_d [NODES];
  logic [IDX_W-1:0]  node_idx_q [NODES];
  logic [IDX_W-1:0]  node_idx_d [NODES];

  // A full output register that is not being drained freezes the whole pipe.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en & ~rst;
  assign accept   = in_valid & in_ready;

  // Next-state of the window: shift on accept, restart the fill on in_sol.
  always_comb begin
    fill_base  = in_sol ? '0 : fill_q;
    fill_inc   = fill_base + CNT_W'(1);
    fill_done  = (fill_inc >= FILL_FULL);
    sol_flag   = in_sol | sol_pend_q;
    win_d      = win_q;
    fill_d     = fill_q;
    sol_pend_d = sol_pend_q;
    mode_d     = mode_q;
    win_vld_d  = 1'b0;
    win_sol_d  = 1'b0;
    if (accept) begin
      for (int k = 0; k < TAPS - 1; k++) begin
        win_d[k] = win_q[k + 1];
      end
      win_d[TAPS-1] = in_data;
      fill_d        = fill_done ? FILL_FULL : fill_inc;
      sol_pend_d    = fill_done ? 1'b0 : sol_flag;
      if (in_sol) begin
        mode_d = mode_norm(mode);
      end
      win_vld_d = fill_done;
      win_sol_d = fill_done & sol_flag;
    end
  end

  // Window, fill counter, pending-sol flag and per-line mode registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        win_q[k] <= '0;
      end
      fill_q     <= '0;
      sol_pend_q <= 1'b0;
      mode_q     <= MODE_MAX;
    end else if (en) begin
      win_q      <= win_d;
      fill_q     <= fill_d;
      sol_pend_q <= sol_pend_d;
      mode_q     <= mode_d;
    end
  end

  // Valid, sol and mode travel alongside the data through every stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      sol_q <= '0;
      for (int l = 0; l < S; l++) begin
        smode_q[l] <= MODE_MAX;
      end
    end else if (en) begin
      vld_q      <= {vld_q[S-1:0], win_vld_d};
      sol_q      <= {sol_q[S-1:0], win_sol_d};
      smode_q[0] <= mode_d;
      for (int l = 1; l < S; l++) begin
        smode_q[l] <= smode_q[l-1];
      end
    end
  end

  // Leaves: in centre mode every leaf carries the centre tap, so the tree
  // returns it unchanged with the same latency as a real comparison.
  always_comb begin
    for (int k = 0; k < TAPS; k++) begin
      leaf_val[k] = (smode_q[0] == MODE_CTR) ? win_q[CTR] : win_q[k];
      leaf_idx[k] = (smode_q[0] == MODE_CTR) ? CTR_IDX : IDX_W'(k);
    end
  end

  for (genvar l = 1; l <= S; l++) begin : g_lvl
    localparam int NIN     = nodes_at(TAPS, l - 1);
    localparam int NOUT    = nodes_at(TAPS, l);
    localparam int OFF_IN  = level_off(TAPS, l - 1);
    localparam int OFF_OUT = level_off(TAPS, l);

    for (genvar j = 0; j < NOUT; j++) begin : g_node
      logic [DATA_W-1:0] a_val;
      logic [IDX_W-1:0]  a_idx;

      if (l == 1) begin : g_a_leaf
        assign a_val = leaf_val[2*j];
        assign a_idx = leaf_idx[2*j];
      end else begin : g_a_reg
        assign a_val = node_val_q[OFF_IN + 2*j];
        assign a_idx = node_idx_q[OFF_IN + 2*j];
      end

      if (2*j + 1 < NIN) begin : g_pair
        logic [DATA_W-1:0] b_val;
        logic [IDX_W-1:0]  b_idx;

        if (l == 1) begin : g_b_leaf
          assign b_val = leaf_val[2*j + 1];
          assign b_idx = leaf_idx[2*j + 1];
        end else begin : g_b_reg
          assign b_val = node_val_q[OFF_IN + 2*j + 1];
          assign b_idx = node_idx_q[OFF_IN + 2*j + 1];
        end

        rank_sel2 #(
          .DATA_W (DATA_W),
          .IDX_W  (IDX_W)
        ) u_sel (
          .mode_i  (smode_q[l-1]),
          .a_val_i (a_val),
          .a_idx_i (a_idx),
          .b_val_i (b_val),
          .b_idx_i (b_idx),
          .val_o   (node_val_d[OFF_OUT + j]),
          .idx_o   (node_idx_d[OFF_OUT + j])
        );
      end else begin : g_pass
        // Odd leftover: forwarded as-is, keeping its own index.
        assign node_val_d[OFF_OUT + j] = a_val;
        assign node_idx_d[OFF_OUT + j] = a_idx;
      end
    end
  end

  // Level registers of the comparator tree; the last node is the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NODES; n++) begin
        node_val_q[n] <= '0;
        node_idx_q[n] <= '0;
      end
    end else if (en) begin
      node_val_q <= node_val_d;
      node_idx_q <= node_idx_d;
    end
  end

  assign out_valid = vld_q[S];
  assign out_sol   = sol_q[S];
  assign out_data  = node_val_q[NODES-1];
  assign out_idx   = node_idx_q[NODES-1];

endmodule
`default_nettype wire
